// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, per-register busy
// (scoreboard) bits, and a post-reset sweep that zeroes every entry.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*AW-1:0]     i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]        o_rs_busy,
  input  logic [NUM_WR*AW-1:0]     i_rd_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_rd_data,
  input  logic [NUM_WR-1:0]        i_rd_wren,
  input  logic                     i_alloc_valid,
  input  logic [AW-1:0]            i_alloc_addr,
  output logic                     o_ready
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic [AW-1:0]       rd_a;
  logic [DATA_W-1:0]   rd_dat;
  logic                rd_bsy;

  // Register 0 is a constant zero source when ZERO_REG is set.
  function automatic logic hw_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Sweep control: CLEAR walks every index once, then hands over to RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    if (state_q == ST_CLEAR) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == LAST_IDX) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Storage update; ascending port order lets the highest port win, and the
  // alloc is applied last so a new producer overrides a same-cycle writeback.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (!i_reset) begin
      if (state_q == ST_CLEAR) begin
        mem_d[idx_q]  = '0;
        busy_d[idx_q] = 1'b0;
      end else begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_rd_wren[w] && !hw_zero(i_rd_addr[w*AW +: AW])) begin
            mem_d[i_rd_addr[w*AW +: AW]]  = i_rd_data[w*DATA_W +: DATA_W];
            busy_d[i_rd_addr[w*AW +: AW]] = 1'b0;
          end
        end
        if (i_alloc_valid && !hw_zero(i_alloc_addr)) begin
          busy_d[i_alloc_addr] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q  <= mem_d;
    busy_q <= busy_d;
  end

  // Combinational read with data and busy bypass from this cycle's writes.
  always_comb begin
    o_rs_data = '0;
    o_rs_busy = '0;
    rd_a      = '0;
    rd_dat    = '0;
    rd_bsy    = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_a   = i_rs_addr[p*AW +: AW];
      rd_dat = mem_q[rd_a];
      rd_bsy = busy_q[rd_a];
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_rd_wren[w] && (i_rd_addr[w*AW +: AW] == rd_a)) begin
          rd_dat = i_rd_data[w*DATA_W +: DATA_W];
          rd_bsy = 1'b0;
        end
      end
      if ((state_q != ST_RUN) || hw_zero(rd_a)) begin
        rd_dat = '0;
        rd_bsy = 1'b0;
      end
      o_rs_data[p*DATA_W +: DATA_W] = rd_dat;
      o_rs_busy[p]                  = rd_bsy;
    end
  end

  assign o_ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios with literal expectations plus a
// per-cycle comparison against an array model of the register file.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*AW-1:0] rs_addr;
  logic [2*DW-1:0] rs_data;
  logic [1:0]      rs_busy;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_wren;
  logic            alloc_valid;
  logic [AW-1:0]   alloc_addr;
  logic            ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  regfile_mp dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_rs_addr     (rs_addr),
    .o_rs_data     (rs_data),
    .o_rs_busy     (rs_busy),
    .i_rd_addr     (rd_addr),
    .i_rd_data     (rd_data),
    .i_rd_wren     (rd_wren),
    .i_alloc_valid (alloc_valid),
    .i_alloc_addr  (alloc_addr),
    .o_ready       (ready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: register contents, busy flags, and cycles of clearing still owed.
  logic [DW-1:0] m_mem  [NR];
  logic          m_busy [NR];
  int            clear_left = NR;
  logic          seen_reset = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      seen_reset <= 1'b1;
      clear_left <= NR;
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else if (clear_left != 0) begin
      clear_left <= clear_left - 1;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (rd_wren[w] && rd_addr[w*AW +: AW] != 0) begin
          m_mem[rd_addr[w*AW +: AW]]  <= rd_data[w*DW +: DW];
          m_busy[rd_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] <= 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (seen_reset) begin
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      logic          eb;
      chk("ready", 64'(ready), 64'(clear_left == 0));
      for (int p = 0; p < 2; p++) begin
        a  = rs_addr[p*AW +: AW];
        ed = m_mem[a];
        eb = m_busy[a];
        for (int w = 0; w < 2; w++) begin
          if (rd_wren[w] && rd_addr[w*AW +: AW] == a) begin
            ed = rd_data[w*DW +: DW];
            eb = 1'b0;
          end
        end
        if (clear_left != 0 || a == 0) begin
          ed = '0;
          eb = 1'b0;
        end
        chk("model_data", 64'(rs_data[p*DW +: DW]), 64'(ed));
        chk("model_busy", 64'(rs_busy[p]), 64'(eb));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_wren     = '0;
    alloc_valid = 1'b0;
  endtask

  task automatic set_wr(int w, logic [AW-1:0] a, logic [DW-1:0] d);
    rd_addr[w*AW +: AW] = a;
    rd_data[w*DW +: DW] = d;
    rd_wren[w]          = 1'b1;
  endtask

  task automatic look(string name, int p, logic [DW-1:0] d, logic b);
    @(negedge clk);
    #1;
    chk({name, "_data"}, 64'(rs_data[p*DW +: DW]), 64'(d));
    chk({name, "_busy"}, 64'(rs_busy[p]), 64'(b));
  endtask

  // Counts cycles with ready low, starting in the cycle after the reset edge.
  task automatic measure_clear(string name);
    int n = 0;
    while (!ready && n < 100) begin
      n++;
      step();
    end
    chk(name, 64'(n), 64'(exp_q.pop_front()));
  endtask

  initial begin
    rst = 1'b1;
    rs_addr = '0;
    rd_addr = '0;
    rd_data = '0;
    idle();
    alloc_addr = '0;
    step();
    step();
    rst = 1'b0;
    exp_q.push_back(32'(NR));
    measure_clear("ready_low_after_reset");

    // All entries read zero after the sweep
    rs_addr = {5'd31, 5'd17};
    look("post_clear_a", 0, 32'h0, 1'b0);
    look("post_clear_b", 1, 32'h0, 1'b0);
    step();

    // Same-cycle bypass, then stored value
    rs_addr[0 +: AW] = 5'd5;
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    look("r5_bypass", 0, 32'hDEAD_BEEF, 1'b0);
    step();
    idle();
    look("r5_stored", 0, 32'hDEAD_BEEF, 1'b0);
    step();

    // Two ports to one register: port 1 wins
    rs_addr = {5'd7, 5'd7};
    set_wr(0, 5'd7, 32'h1111_1111);
    set_wr(1, 5'd7, 32'h2222_2222);
    look("r7_bypass_p0", 0, 32'h2222_2222, 1'b0);
    look("r7_bypass_p1", 1, 32'h2222_2222, 1'b0);
    step();
    idle();
    look("r7_stored", 1, 32'h2222_2222, 1'b0);
    step();

    // Busy tracking on r3
    rs_addr[AW +: AW] = 5'd3;
    alloc_valid = 1'b1;
    alloc_addr  = 5'd3;
    look("r3_alloc_same_cycle", 1, 32'h0, 1'b0);
    step();
    idle();
    look("r3_busy", 1, 32'h0, 1'b1);
    set_wr(1, 5'd3, 32'h5);
    look("r3_write_bypass", 1, 32'h5, 1'b0);
    step();
    idle();
    look("r3_after_write", 1, 32'h5, 1'b0);
    set_wr(0, 5'd3, 32'h77);
    alloc_valid = 1'b1;
    alloc_addr  = 5'd3;
    look("r3_alloc_and_write", 1, 32'h77, 1'b0);
    step();
    idle();
    look("r3_new_producer", 1, 32'h77, 1'b1);
    step();

    // Register 0 stays zero and never busy
    rs_addr = {5'd0, 5'd0};
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    alloc_valid = 1'b1;
    alloc_addr  = 5'd0;
    look("r0_write_bypass", 0, 32'h0, 1'b0);
    step();
    idle();
    look("r0_after", 1, 32'h0, 1'b0);
    step();

    // Mixed traffic over a small address window to force collisions
    for (int c = 0; c < 60; c++) begin
      rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_data     = {32'($urandom), 32'($urandom)};
      rd_wren     = 2'($urandom_range(0, 3));
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_addr  = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    step();

    // Reset during the sweep restarts it and wipes prior contents
    rs_addr[0 +: AW] = 5'd9;
    set_wr(0, 5'd9, 32'hA);
    step();
    idle();
    look("r9_written", 0, 32'hA, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.push_back(32'(NR));
    measure_clear("ready_low_after_mid_clear_reset");
    look("r9_cleared", 0, 32'h0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
